// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, field positions and state encoding for alu_issue_ctrl.
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_op_add  = 4'h0;
    localparam logic [3:0] c_op_sub  = 4'h1;
    localparam logic [3:0] c_op_gti  = 4'h2;
    localparam logic [3:0] c_op_and  = 4'h3;
    localparam logic [3:0] c_op_or   = 4'h4;
    localparam logic [3:0] c_op_xor  = 4'h5;
    localparam logic [3:0] c_op_andi = 4'h6;
    localparam logic [3:0] c_op_ori  = 4'h7;
    localparam logic [3:0] c_op_xori = 4'h8;
    localparam logic [3:0] c_op_addi = 4'h9;
    localparam logic [3:0] c_op_subi = 4'hA;
    localparam logic [3:0] c_op_last = c_op_subi;

    localparam int c_op_hi = 15;
    localparam int c_op_lo = 12;
    localparam int c_rd_hi = 11;
    localparam int c_rd_lo = 8;
    localparam int c_rs_hi = 7;
    localparam int c_rs_lo = 4;
    localparam int c_rt_hi = 3;
    localparam int c_rt_lo = 0;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_read = 3'd1;
    localparam logic [2:0] c_st_exec = 3'd2;
    localparam logic [2:0] c_st_wb   = 3'd3;
`ifdef ALU_ISSUE_TRAP_EN
    localparam logic [2:0] c_st_trap = 3'd4;
`endif

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= c_op_last;
    endfunction

    // gt-imm sits between the register ops in the opcode map
    function automatic logic op_is_imm(input logic [3:0] op);
        return (op == c_op_gti) || ((op >= c_op_andi) && (op <= c_op_subi));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_regfile
// Description : NREGS x DATA_W register file, two async reads, one sync write,
//               R0 hardwired to zero, async clear.
// Revision    : 1.0
// ============================================================================
module alu_issue_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [AW-1:0]     i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] w_mem [NREGS];

    assign w_mem[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (i_we && (i_waddr == AW'(gi))) begin
                    r_q <= i_wdata;
                end
            end
            assign w_mem[gi] = r_q;
        end
    endgenerate

    assign o_rdata_a = w_mem[i_raddr_a];
    assign o_rdata_b = w_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Four-cycle issue controller driving a combinational 16-bit ALU
//               and writing its result back to a 16x16 register file.
//               Define ALU_ISSUE_TRAP_EN to trap on illegal opcodes.
// Revision    : 1.0
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_select,
    output logic [3:0]        alu_imm,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    logic [2:0]        r_state;
    logic [15:0]       r_instr;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_alu_sel;
    logic [3:0]        r_alu_imm;

    logic [3:0]        w_op;
    logic [3:0]        w_rd;
    logic [3:0]        w_rs;
    logic [3:0]        w_rt;
    logic              w_legal;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata_s;
    logic [DATA_W-1:0] w_rdata_t;

    assign w_op    = r_instr[c_op_hi:c_op_lo];
    assign w_rd    = r_instr[c_rd_hi:c_rd_lo];
    assign w_rs    = r_instr[c_rs_hi:c_rs_lo];
    assign w_rt    = r_instr[c_rt_hi:c_rt_lo];
    assign w_legal = op_is_legal(w_op);
    assign w_we    = (r_state == c_st_wb) && w_legal;

    alu_issue_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (4)
    ) u_regfile (
        .clk       (clock),
        .rst       (reset),
        .i_we      (w_we),
        .i_waddr   (w_rd),
        .i_wdata   (r_result),
        .i_raddr_a (w_rs),
        .o_rdata_a (w_rdata_s),
        .i_raddr_b (w_rt),
        .o_rdata_b (w_rdata_t)
    );

`ifdef ALU_ISSUE_TRAP_EN
    logic r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_instr   <= '0;
            r_result  <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_alu_imm <= '0;
`ifdef ALU_ISSUE_TRAP_EN
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (instr_valid) begin
                        r_instr <= instr;
`ifdef ALU_ISSUE_TRAP_EN
                        if (!op_is_legal(instr[c_op_hi:c_op_lo])) begin
                            r_state <= c_st_trap;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= c_st_read;
                        end
`else
                        r_state <= c_st_read;
`endif
                    end
                end
                c_st_read: begin
                    // Illegal words leave the ALU inputs untouched
                    if (w_legal) begin
                        r_alu_sel <= w_op;
                        if (op_is_imm(w_op)) begin
                            r_alu_a   <= '0;
                            r_alu_b   <= w_rdata_s;
                            r_alu_imm <= w_rt;
                        end else begin
                            r_alu_a   <= w_rdata_s;
                            r_alu_b   <= w_rdata_t;
                            r_alu_imm <= '0;
                        end
                    end
                    r_state <= c_st_exec;
                end
                c_st_exec: begin
                    r_result <= alu_result;
                    r_state  <= c_st_wb;
                end
                c_st_wb: begin
                    r_state <= c_st_idle;
                end
`ifdef ALU_ISSUE_TRAP_EN
                c_st_trap: begin
                    r_state <= c_st_trap;
                end
`endif
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign instr_ready = (r_state == c_st_idle);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_select  = r_alu_sel;
    assign alu_imm     = r_alu_imm;
    assign wb_valid    = w_we;
    assign wb_addr     = w_rd;
    assign wb_data     = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed self-checking bench for alu_issue_ctrl with a small
//               behavioural ALU attached to its initiator port.
// Revision    : 1.0
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_select;
    logic [3:0]  alu_imm;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        err;

    int errors = 0;
    int checks = 0;

    alu_issue_ctrl #(.DATA_W(16), .NREGS(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_select  (alu_select),
        .alu_imm     (alu_imm),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        alu_result = 16'h0000;
        case (alu_select)
            4'h0: alu_result = alu_a + alu_b;
            4'h1: alu_result = alu_a - alu_b;
            4'h2: alu_result = (alu_b > {12'h000, alu_imm}) ? 16'h0001 : 16'h0000;
            4'h3: alu_result = alu_a & alu_b;
            4'h4: alu_result = alu_a | alu_b;
            4'h5: alu_result = alu_a ^ alu_b;
            4'h6: alu_result = alu_b & {12'h000, alu_imm};
            4'h7: alu_result = alu_b | {12'h000, alu_imm};
            4'h8: alu_result = alu_b ^ {12'h000, alu_imm};
            4'h9: alu_result = alu_b + {12'h000, alu_imm};
            4'hA: alu_result = alu_b - {12'h000, alu_imm};
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_timeout", {15'd0, instr_ready}, 16'h0001);
    endtask

    // Issue one word starting on a negedge and check cycles 1..4.
    task automatic issue(input logic [15:0] word, input logic chk_alu,
                         input logic [15:0] ea, input logic [15:0] eb,
                         input logic [3:0] esel, input logic [3:0] eimm,
                         input logic ewbv, input logic [3:0] eaddr,
                         input logic [15:0] edata, input logic junk);
        wait_ready();
        instr_valid = 1'b1;
        instr       = word;
        @(negedge clock);
        if (junk) begin
            instr = 16'h9F0F;
        end else begin
            instr_valid = 1'b0;
        end
        chk("c1_ready", {15'd0, instr_ready}, 16'h0000);
        @(negedge clock);
        chk("c2_wbv", {15'd0, wb_valid}, 16'h0000);
        if (chk_alu) begin
            chk("c2_alu_a", alu_a, ea);
            chk("c2_alu_b", alu_b, eb);
            chk("c2_alu_sel", {12'd0, alu_select}, {12'd0, esel});
            chk("c2_alu_imm", {12'd0, alu_imm}, {12'd0, eimm});
        end
        @(negedge clock);
        chk("c3_wbv", {15'd0, wb_valid}, {15'd0, ewbv});
        if (ewbv) begin
            chk("c3_wb_addr", {12'd0, wb_addr}, {12'd0, eaddr});
            chk("c3_wb_data", wb_data, edata);
        end
        @(negedge clock);
        instr_valid = 1'b0;
        chk("c4_ready", {15'd0, instr_ready}, 16'h0001);
        chk("c4_wbv", {15'd0, wb_valid}, 16'h0000);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        @(negedge clock);
        @(negedge clock);
        chk("rst_ready", {15'd0, instr_ready}, 16'h0001);
        chk("rst_alu_a", alu_a, 16'h0000);
        chk("rst_alu_b", alu_b, 16'h0000);
        chk("rst_sel", {12'd0, alu_select}, 16'h0000);
        chk("rst_imm", {12'd0, alu_imm}, 16'h0000);
        chk("rst_wbv", {15'd0, wb_valid}, 16'h0000);
        chk("rst_wb_addr", {12'd0, wb_addr}, 16'h0000);
        chk("rst_wb_data", wb_data, 16'h0000);
        chk("rst_err", {15'd0, err}, 16'h0000);
        reset = 1'b0;
        @(negedge clock);

        issue(16'h9105, 1'b1, 16'h0000, 16'h0000, 4'h9, 4'h5, 1'b1, 4'h1, 16'h0005, 1'b0);
        issue(16'h0211, 1'b1, 16'h0005, 16'h0005, 4'h0, 4'h0, 1'b1, 4'h2, 16'h000A, 1'b0);
        issue(16'h1301, 1'b1, 16'h0000, 16'h0005, 4'h1, 4'h0, 1'b1, 4'h3, 16'hFFFB, 1'b0);
        issue(16'h2413, 1'b1, 16'h0000, 16'h0005, 4'h2, 4'h3, 1'b1, 4'h4, 16'h0001, 1'b0);
        issue(16'h2417, 1'b1, 16'h0000, 16'h0005, 4'h2, 4'h7, 1'b1, 4'h4, 16'h0000, 1'b0);
        issue(16'h9007, 1'b1, 16'h0000, 16'h0000, 4'h9, 4'h7, 1'b1, 4'h0, 16'h0007, 1'b0);
        issue(16'h0500, 1'b1, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b1, 4'h5, 16'h0000, 1'b0);
        // xor r7,r2,r3 while junk is presented outside IDLE
        issue(16'h5723, 1'b1, 16'h000A, 16'hFFFB, 4'h5, 4'h0, 1'b1, 4'h7, 16'hFFF1, 1'b1);
        // r15 must still be zero: the junk word was never consumed
        issue(16'h06F0, 1'b1, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b1, 4'h6, 16'h0000, 1'b0);
        issue(16'hA823, 1'b1, 16'h0000, 16'h000A, 4'hA, 4'h3, 1'b1, 4'h8, 16'h0007, 1'b0);

`ifdef ALU_ISSUE_TRAP_EN
        wait_ready();
        instr_valid = 1'b1;
        instr       = 16'hB000;
        @(negedge clock);
        instr_valid = 1'b0;
        chk("trap_err", {15'd0, err}, 16'h0001);
        chk("trap_ready", {15'd0, instr_ready}, 16'h0000);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clock);
                if (instr_ready !== 1'b0 || wb_valid !== 1'b0) seen = 1'b1;
            end
            chk("trap_park", {15'd0, seen}, 16'h0000);
        end
        reset = 1'b1;
        #1;
        chk("trap_rst_err", {15'd0, err}, 16'h0000);
        chk("trap_rst_ready", {15'd0, instr_ready}, 16'h0001);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue(16'h9105, 1'b1, 16'h0000, 16'h0000, 4'h9, 4'h5, 1'b1, 4'h1, 16'h0005, 1'b0);
`else
        issue(16'hB000, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0, 16'h0000, 1'b0);
        chk("nop_err", {15'd0, err}, 16'h0000);
`endif

        // Reset during EXEC of addi r1,r0,5 aborts the write
        wait_ready();
        instr_valid = 1'b1;
        instr       = 16'h9105;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_ready", {15'd0, instr_ready}, 16'h0001);
        chk("abort_wbv", {15'd0, wb_valid}, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                if (wb_valid !== 1'b0) seen = 1'b1;
            end
            chk("abort_no_wb", {15'd0, seen}, 16'h0000);
        end
        // add r6,r1,r0 shows r1 was cleared
        issue(16'h0610, 1'b1, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b1, 4'h6, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
